// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the key-play detector: key width, debounce default, FSM codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package detector_jogada_pkg;

    localparam int KEY_W                   = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    // Codes are shown directly on the debug 7-segment display, so they are fixed.
    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        FILTRA = 2'd1,
        EMITE  = 2'd2,
        SOLTA  = 2'd3
    } estado_t;

    // True when exactly one key is pressed.
    function automatic logic eh_one_hot(input logic [KEY_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/detector_jogada_sincronizador_2ff.sv
// Two-flop synchronizer bringing asynchronous switch levels into the clock domain.
// Latency: 2 cycles from input change to q.
// Backpressure: none; samples every cycle.
module sincronizador_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/detector_jogada.sv
// Debounces the player keys and emits one registered play strobe per stable press (optional one-hot check via DETECTOR_JOGADA_ONEHOT_EN).
// Latency: strobe is high in the cycle after edge DEBOUNCE_CYCLES+3, counting from the first edge that sees a stable pattern.
// Backpressure: habilita gates acceptance of a new play; a held key yields one strobe and a debounced release is needed before the next.
module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [KEY_W-1:0] chaves,
    input  logic             habilita,
    output logic [KEY_W-1:0] jogada,
    output logic             jogada_feita,
    output logic             jogada_invalida,
    output logic [3:0]       db_estado
);

    // Counters only ever reach DEBOUNCE_CYCLES-1, so clog2 bits never wrap.
    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    estado_t          estado;
    logic [KEY_W-1:0] s;
    logic [KEY_W-1:0] candidato;
    logic [CNT_W-1:0] contador;
    logic [CNT_W-1:0] contador_solta;

    sincronizador_2ff #(
        .WIDTH (KEY_W)
    ) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (chaves),
        .q     (s)
    );

    assign db_estado = {2'b00, estado};

`ifndef DETECTOR_JOGADA_ONEHOT_EN
    assign jogada_invalida = 1'b0;
`endif

    // Play FSM; the strobe and jogada are registered on the transition into EMITE
    // so the pulse is visible exactly while db_estado shows EMITE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado         <= ESPERA;
            candidato      <= '0;
            contador       <= '0;
            contador_solta <= '0;
            jogada         <= '0;
            jogada_feita   <= 1'b0;
`ifdef DETECTOR_JOGADA_ONEHOT_EN
            jogada_invalida <= 1'b0;
`endif
        end else begin
            jogada_feita <= 1'b0;
`ifdef DETECTOR_JOGADA_ONEHOT_EN
            jogada_invalida <= 1'b0;
`endif
            case (estado)
                ESPERA: begin
                    if (habilita && (s != '0)) begin
                        candidato <= s;
                        contador  <= '0;
                        estado    <= FILTRA;
                    end
                end
                FILTRA: begin
                    // Losing permission abandons the filter before anything else.
                    if (!habilita) begin
                        estado <= ESPERA;
                    end else if (s == candidato) begin
                        if (contador == CNT_MAX) begin
                            jogada <= candidato;
`ifdef DETECTOR_JOGADA_ONEHOT_EN
                            if (eh_one_hot(candidato)) begin
                                jogada_feita <= 1'b1;
                            end else begin
                                jogada_invalida <= 1'b1;
                            end
`else
                            jogada_feita <= 1'b1;
`endif
                            estado <= EMITE;
                        end else begin
                            contador <= contador + 1'b1;
                        end
                    end else if (s == '0) begin
                        estado <= ESPERA;
                    end else begin
                        candidato <= s;
                        contador  <= '0;
                    end
                end
                EMITE: begin
                    contador_solta <= '0;
                    estado         <= SOLTA;
                end
                SOLTA: begin
                    // Release must itself be debounced; any pressed key restarts the count.
                    if (s != '0) begin
                        contador_solta <= '0;
                    end else if (contador_solta == CNT_MAX) begin
                        estado <= ESPERA;
                    end else begin
                        contador_solta <= contador_solta + 1'b1;
                    end
                end
                default: estado <= ESPERA;
            endcase
        end
    end

endmodule
